// File: rtl/qea_run_sequencer.sv
// Host-side job sequencer for the QEA core: loads context and state RAMs,
// starts the core, times the run, then streams final state rows back out.
module qea_run_sequencer #(
  parameter int PE_NUM_WIDTH     = 2,
  parameter int PE_NUM           = 4,
  parameter int STATE_DATA_WIDTH = 64,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int CTX_DATA_WIDTH   = 64,
  parameter int CTX_ADDR_WIDTH   = 16,
  parameter int MAX_QBIT_WIDTH   = 6,
  parameter int RD_LAT           = 1,
  parameter int TIMEOUT_W        = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_job_go,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [CTX_ADDR_WIDTH:0]              i_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [CTX_DATA_WIDTH-1:0]            i_ctx_word,
  input  logic                                 i_st_valid,
  output logic                                 o_st_ready,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_st_row,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_out_row,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [CTX_ADDR_WIDTH-1:0]            o_ctx_addr,
  output logic [CTX_DATA_WIDTH-1:0]            o_ctx_data,
  output logic [PE_NUM-1:0]                    o_state_ena,
  output logic [PE_NUM-1:0]                    o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_dout,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [TIMEOUT_W-1:0]                 o_run_cycles
);

  localparam int CNT_W = ((CTX_ADDR_WIDTH > STATE_ADDR_WIDTH) ? CTX_ADDR_WIDTH : STATE_ADDR_WIDTH) + 1;
  localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;
  localparam int LAT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_CTX, S_LOAD_ST, S_START, S_RUN, S_READ, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, ins_q, ins_d, rows_q, rows_d, cnt_inc;
  logic [MAX_QBIT_WIDTH-1:0] qbit_q, qbit_d;
  logic                      ctx_en_q, ctx_en_d;
  logic [CTX_ADDR_WIDTH-1:0] ctx_addr_q, ctx_addr_d;
  logic [CTX_DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
  logic                      st_ena_q, st_ena_d, st_wea_q, st_wea_d;
  logic [STATE_ADDR_WIDTH-1:0] st_addr_q, st_addr_d;
  logic [ROW_W-1:0]          st_dina_q, st_dina_d;
  logic [TIMEOUT_W-1:0]      run_q, run_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic                      pend_q, pend_d;
  logic                      out_valid_q, out_valid_d;
  logic [ROW_W-1:0]          out_row_q, out_row_d;
  logic                      err_q, err_d;
  logic                      qbit_ok, ctx_fire, st_fire;

  assign qbit_ok  = (int'(i_qbit_num) > PE_NUM_WIDTH) &&
                    (int'(i_qbit_num) <= STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  assign ctx_fire = i_ctx_valid && (state_q == S_LOAD_CTX);
  assign st_fire  = i_st_valid && (state_q == S_LOAD_ST);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ins_d       = ins_q;
    rows_d      = rows_q;
    qbit_d      = qbit_q;
    ctx_en_d    = 1'b0;
    ctx_addr_d  = ctx_addr_q;
    ctx_data_d  = ctx_data_q;
    st_ena_d    = 1'b0;
    st_wea_d    = 1'b0;
    st_addr_d   = st_addr_q;
    st_dina_d   = st_dina_q;
    run_d       = run_q;
    lat_d       = lat_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_job_go) begin
          if (!qbit_ok) begin
            err_d = 1'b1;
          end else begin
            qbit_d  = i_qbit_num;
            ins_d   = CNT_W'(i_ins_num);
            rows_d  = CNT_W'(1) << (i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH));
            cnt_d   = '0;
            state_d = (i_ins_num == '0) ? S_LOAD_ST : S_LOAD_CTX;
          end
        end
      end
      S_LOAD_CTX: begin
        if (ctx_fire) begin
          ctx_en_d   = 1'b1;
          ctx_addr_d = cnt_q[CTX_ADDR_WIDTH-1:0];
          ctx_data_d = i_ctx_word;
          if (cnt_q == ins_q - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_LOAD_ST;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_LOAD_ST: begin
        if (st_fire) begin
          st_ena_d  = 1'b1;
          st_wea_d  = 1'b1;
          st_addr_d = cnt_q[STATE_ADDR_WIDTH-1:0];
          st_dina_d = i_st_row;
          if (cnt_q == rows_q - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_START: begin
        run_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (run_q != '1) run_d = run_q + TIMEOUT_W'(1);
        // The first row read is issued on the same edge that leaves RUN.
        if (i_qea_complete) begin
          state_d   = S_READ;
          cnt_d     = '0;
          st_ena_d  = 1'b1;
          st_addr_d = '0;
          lat_d     = LAT_W'(RD_LAT);
          pend_d    = 1'b1;
        end
      end
      S_READ: begin
        if (pend_q) begin
          if (lat_q == '0) begin
            out_row_d   = i_qea_dout;
            out_valid_d = 1'b1;
            pend_d      = 1'b0;
          end else begin
            lat_d = lat_q - LAT_W'(1);
          end
        end else if (out_valid_q && i_out_ready) begin
          out_valid_d = 1'b0;
          if (cnt_q == rows_q - CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d     = cnt_inc;
            st_ena_d  = 1'b1;
            st_addr_d = cnt_inc[STATE_ADDR_WIDTH-1:0];
            lat_d     = LAT_W'(RD_LAT);
            pend_d    = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ins_q       <= '0;
      rows_q      <= '0;
      qbit_q      <= '0;
      ctx_en_q    <= 1'b0;
      ctx_addr_q  <= '0;
      ctx_data_q  <= '0;
      st_ena_q    <= 1'b0;
      st_wea_q    <= 1'b0;
      st_addr_q   <= '0;
      st_dina_q   <= '0;
      run_q       <= '0;
      lat_q       <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ins_q       <= ins_d;
      rows_q      <= rows_d;
      qbit_q      <= qbit_d;
      ctx_en_q    <= ctx_en_d;
      ctx_addr_q  <= ctx_addr_d;
      ctx_data_q  <= ctx_data_d;
      st_ena_q    <= st_ena_d;
      st_wea_q    <= st_wea_d;
      st_addr_q   <= st_addr_d;
      st_dina_q   <= st_dina_d;
      run_q       <= run_d;
      lat_q       <= lat_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      err_q       <= err_d;
    end
  end

  assign o_ctx_ready    = (state_q == S_LOAD_CTX);
  assign o_st_ready     = (state_q == S_LOAD_ST);
  assign o_qea_start    = (state_q == S_START);
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE);
  assign o_err          = err_q;
  assign o_out_valid    = out_valid_q;
  assign o_out_row      = out_row_q;
  assign o_qea_qbit_num = qbit_q;
  assign o_ctx_en       = ctx_en_q;
  assign o_ctx_wea      = ctx_en_q;
  assign o_ctx_addr     = ctx_addr_q;
  assign o_ctx_data     = ctx_data_q;
  assign o_state_ena    = {PE_NUM{st_ena_q}};
  assign o_state_wea    = {PE_NUM{st_wea_q}};
  assign o_state_addra  = st_addr_q;
  assign o_state_dina   = st_dina_q;
  assign o_run_cycles   = run_q;

endmodule

// File: tb/tb_qea_run_sequencer.sv
// Randomized job-level bench for qea_run_sequencer with a mock QEA/state RAM.
module tb_qea_run_sequencer;
  localparam int ROW_W = 256;

  logic clk = 1'b0;
  logic rst, go, ctx_valid, ctx_ready, st_valid, st_ready, out_valid, out_ready;
  logic [5:0] qbit_num, qea_qbit;
  logic [16:0] ins_num;
  logic [63:0] ctx_word, ctx_data;
  logic [ROW_W-1:0] st_row, out_row, state_dina, qea_dout;
  logic qea_start, ctx_en, ctx_wea, qea_complete, busy, done, err;
  logic [15:0] ctx_addr, state_addra;
  logic [3:0] state_ena, state_wea;
  logic [31:0] run_cycles;

  qea_run_sequencer #(
    .PE_NUM_WIDTH(2), .PE_NUM(4), .STATE_DATA_WIDTH(64), .STATE_ADDR_WIDTH(16),
    .CTX_DATA_WIDTH(64), .CTX_ADDR_WIDTH(16), .MAX_QBIT_WIDTH(6), .RD_LAT(1), .TIMEOUT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .i_job_go(go), .i_qbit_num(qbit_num), .i_ins_num(ins_num),
    .i_ctx_valid(ctx_valid), .o_ctx_ready(ctx_ready), .i_ctx_word(ctx_word),
    .i_st_valid(st_valid), .o_st_ready(st_ready), .i_st_row(st_row),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_row(out_row),
    .o_qea_start(qea_start), .o_qea_qbit_num(qea_qbit), .o_ctx_en(ctx_en), .o_ctx_wea(ctx_wea),
    .o_ctx_addr(ctx_addr), .o_ctx_data(ctx_data), .o_state_ena(state_ena), .o_state_wea(state_wea),
    .o_state_addra(state_addra), .o_state_dina(state_dina), .i_qea_complete(qea_complete),
    .i_qea_dout(qea_dout), .o_busy(busy), .o_done(done), .o_err(err), .o_run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Mock state RAM; the "computation" inverts every stored row on complete.
  logic [ROW_W-1:0] mem [0:63];
  always @(posedge clk) begin
    if (qea_complete) begin
      for (int i = 0; i < 64; i++) mem[i] <= ~mem[i];
    end else if (state_ena[0] && state_wea[0]) begin
      mem[state_addra[5:0]] <= state_dina;
    end else if (state_ena[0] && !state_wea[0]) begin
      qea_dout <= mem[state_addra[5:0]];
    end
  end

  int checks = 0, errors = 0;
  task automatic chk(input bit ok, input string nm, input logic [ROW_W-1:0] act,
                     input logic [ROW_W-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  logic [63:0]      exp_ctx [0:255];
  logic [ROW_W-1:0] exp_st  [0:63];

  // Job-level model state, advanced once per cycle by the compare process.
  bit mon_en = 1'b0;
  bit active, exp_ctx_en, exp_st_en, exp_err, prev_hold;
  int ins_c, rows_c, qbit_c, ctx_acc, st_acc, exp_ctx_addr, exp_st_addr;
  int ctx_wr, st_wr, rd_n, out_idx, start_n, done_n, err_n;
  logic [ROW_W-1:0] prev_orow;

  initial begin
    active = 0; exp_ctx_en = 0; exp_st_en = 0; exp_err = 0; prev_hold = 0;
    ins_c = 0; rows_c = 0; qbit_c = 0; ctx_acc = 0; st_acc = 0;
    exp_ctx_addr = 0; exp_st_addr = 0;
    ctx_wr = 0; st_wr = 0; rd_n = 0; out_idx = 0; start_n = 0; done_n = 0; err_n = 0;
    prev_orow = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk(busy == active, "busy", busy, active);
        chk(ctx_ready == (active && ctx_acc < ins_c), "ctx_ready", ctx_ready, 0);
        chk(st_ready == (active && ctx_acc == ins_c && st_acc < rows_c), "st_ready", st_ready, 0);
        chk(ctx_en == exp_ctx_en && ctx_wea == exp_ctx_en, "ctx_strobe", ctx_en, exp_ctx_en);
        if (exp_ctx_en) begin
          chk(ctx_addr == 16'(exp_ctx_addr), "ctx_addr", ctx_addr, exp_ctx_addr);
          chk(ctx_data == exp_ctx[exp_ctx_addr], "ctx_data", ctx_data, exp_ctx[exp_ctx_addr]);
        end
        if (ctx_en) ctx_wr++;
        chk(state_wea == (exp_st_en ? 4'hF : 4'h0), "st_wea", state_wea, exp_st_en);
        if (exp_st_en) begin
          chk(state_ena == 4'hF && state_addra == 16'(exp_st_addr), "st_wr_addr", state_addra, exp_st_addr);
          chk(state_dina == exp_st[exp_st_addr], "st_wr_data", state_dina, exp_st[exp_st_addr]);
          st_wr++;
        end
        if (state_ena != 4'h0 && state_wea == 4'h0) begin
          rd_n++;
          chk(state_ena == 4'hF && !out_valid, "rd_issue", state_ena, 4'hF);
        end
        chk(err == exp_err, "err", err, exp_err);
        if (active) chk(qea_qbit == 6'(qbit_c), "qbit_num", qea_qbit, qbit_c);
        if (prev_hold) chk(out_valid && out_row == prev_orow, "out_stable", out_row, prev_orow);
        if (out_valid && out_ready) begin
          if (out_idx < rows_c) chk(out_row == ~exp_st[out_idx], "out_row", out_row, ~exp_st[out_idx]);
          else chk(0, "out_extra", out_idx, rows_c);
          out_idx++;
        end
        if (rst) begin
          active = 0; exp_ctx_en = 0; exp_st_en = 0; exp_err = 0; prev_hold = 0;
        end else begin
          exp_ctx_en = ctx_valid && ctx_ready;
          exp_ctx_addr = ctx_acc;
          if (exp_ctx_en) ctx_acc++;
          exp_st_en = st_valid && st_ready;
          exp_st_addr = st_acc;
          if (exp_st_en) st_acc++;
          exp_err = go && !active && (qbit_num <= 2 || qbit_num > 18);
          if (go && !active && !(qbit_num <= 2 || qbit_num > 18)) begin
            active = 1; qbit_c = int'(qbit_num); ins_c = int'(ins_num);
            rows_c = 1 << (qbit_c - 2);
            ctx_acc = 0; st_acc = 0; ctx_wr = 0; st_wr = 0; rd_n = 0;
            out_idx = 0; start_n = 0;
          end
          if (qea_start) start_n++;
          if (done) begin done_n++; active = 0; end
          if (err) err_n++;
          prev_hold = out_valid && !out_ready;
          prev_orow = out_row;
        end
      end
    end
  end

  task automatic drive_ctx(input int n);
    for (int i = 0; i < n; i++) begin
      int t; bit hs;
      ctx_valid = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      ctx_valid = 1; ctx_word = exp_ctx[i];
      t = 0; hs = 0;
      while (!hs && t < 5000) begin
        @(negedge clk); hs = ctx_ready;
        @(posedge clk); #1; t++;
      end
      if (!hs) chk(0, "ctx_timeout", i, n);
    end
    ctx_valid = 0;
  endtask

  task automatic drive_st(input int n);
    for (int i = 0; i < n; i++) begin
      int t; bit hs;
      st_valid = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      st_valid = 1; st_row = exp_st[i];
      t = 0; hs = 0;
      while (!hs && t < 5000) begin
        @(negedge clk); hs = st_ready;
        @(posedge clk); #1; t++;
      end
      if (!hs) chk(0, "st_timeout", i, n);
    end
    st_valid = 0;
  endtask

  task automatic mock_qea(input int delay);
    int t = 0;
    while (!qea_start && t < 5000) begin @(posedge clk); #1; t++; end
    if (!qea_start) begin
      chk(0, "start_timeout", t, 0);
    end else begin
      repeat (delay) @(posedge clk);
      #1 qea_complete = 1;
      @(posedge clk); #1 qea_complete = 0;
    end
  endtask

  task automatic consume(input int rows, input int stall_row);
    for (int i = 0; i < rows; i++) begin
      int t = 0;
      out_ready = 0;
      while (!out_valid && t < 5000) begin @(posedge clk); #1; t++; end
      if (!out_valid) begin
        chk(0, "out_timeout", i, rows);
        return;
      end
      repeat ((i == stall_row) ? 10 : $urandom_range(0, 2)) begin @(posedge clk); #1; end
      out_ready = 1;
      @(posedge clk); #1 out_ready = 0;
    end
  endtask

  task automatic fill(input int ins, input int rows);
    for (int i = 0; i < ins; i++) exp_ctx[i] = {$urandom(), $urandom()};
    for (int i = 0; i < rows; i++)
      for (int k = 0; k < 8; k++) exp_st[i][k*32 +: 32] = $urandom();
  endtask

  task automatic pulse_go(input int q, input int ins);
    go = 1; qbit_num = 6'(q); ins_num = 17'(ins);
    @(posedge clk); #1 go = 0;
  endtask

  task automatic run_job(input int q, input int ins, input int stall_row, input int delay);
    int rows = 1 << (q - 2);
    int d0 = done_n;
    int t = 0;
    fill(ins, rows);
    pulse_go(q, ins);
    fork
      drive_ctx(ins);
      drive_st(rows);
      mock_qea(delay);
      consume(rows, stall_row);
    join
    while (done_n == d0 && t < 200) begin @(posedge clk); #1; t++; end
    chk(done_n == d0 + 1, "done_pulses", done_n - d0, 1);
    chk(ctx_wr == ins, "ctx_writes", ctx_wr, ins);
    chk(st_wr == rows, "st_writes", st_wr, rows);
    chk(start_n == 1, "start_pulses", start_n, 1);
    chk(out_idx == rows, "out_rows", out_idx, rows);
    chk(rd_n == rows, "ram_reads", rd_n, rows);
    chk(run_cycles == 32'(delay), "run_cycles", run_cycles, delay);
    chk(!busy, "idle_after_job", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int e0;
    rst = 1; go = 0; qbit_num = 0; ins_num = 0; ctx_valid = 0; ctx_word = 0;
    st_valid = 0; st_row = '0; out_ready = 0; qea_complete = 0;
    repeat (3) @(posedge clk);
    #1;
    chk(!busy && !out_valid && !qea_start && !done && !err, "reset_status", busy, 0);
    chk(run_cycles == 0 && !ctx_en && state_ena == 0, "reset_outputs", run_cycles, 0);
    rst = 0;
    mon_en = 1;
    @(posedge clk); #1;

    // Illegal qubit counts: single error pulse, no job.
    e0 = err_n;
    pulse_go(2, 4);
    chk(err == 1 && busy == 0, "err_qbit2", {err, busy}, 2'b10);
    @(posedge clk); #1;
    chk(err == 0 && busy == 0, "err_pulse_len", {err, busy}, 2'b00);
    pulse_go(19, 4);
    @(posedge clk); #1;
    chk(err_n == e0 + 2, "err_count", err_n - e0, 2);

    // No context load, 2 rows.
    run_job(3, 0, -1, 7);
    chk(st_wr == 2 && out_idx == 2, "t3_rows", st_wr, 2);

    // 145 context words, 32 rows, stall on out row 3.
    run_job(7, 145, 3, $urandom_range(20, 40));
    chk(ctx_wr == 145 && st_wr == 32, "t2_counts", {ctx_wr, st_wr}, {32'd145, 32'd32});

    run_job(4, 5, -1, 1000);
    chk(run_cycles == 32'd1000, "t5_run_cycles", run_cycles, 1000);

    // Reset while row 5 is being offered in the state load.
    fill(3, 8);
    pulse_go(5, 3);
    drive_ctx(3);
    drive_st(5);
    st_valid = 1; st_row = exp_st[5]; rst = 1;
    @(posedge clk); #1;
    chk(!busy && !ctx_en && state_ena == 0 && !st_ready && !ctx_ready, "t1_abort",
        {busy, ctx_en, state_ena}, 0);
    rst = 0; st_valid = 0;
    @(posedge clk); #1;
    chk(st_wr == 5 && !busy, "t1_writes", st_wr, 5);

    run_job(5, 10, -1, 3);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
